// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor (package sersub_pkg).
package sersub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sersub_state_t;

    localparam int SERSUB_DEFAULT_WIDTH = 5;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle between the io wrapper (master) and the subtractor (slave).
// zero_o exists only when SERSUB_ZERO_FLAG_EN is defined.
interface serial_subtractor_if
    import sersub_pkg::*;
#(
    parameter int WIDTH = SERSUB_DEFAULT_WIDTH
);
    logic             start_i;
    logic             a_i;
    logic             b_i;
    logic             diff_o;
    logic             diff_vld_o;
    logic             busy_o;
    logic             done_o;
    logic             borrow_o;
    logic [WIDTH-1:0] result_o;
`ifdef SERSUB_ZERO_FLAG_EN
    logic             zero_o;

    modport master (
        output start_i, a_i, b_i,
        input  diff_o, diff_vld_o, busy_o, done_o, borrow_o, result_o, zero_o
    );
    modport slave (
        input  start_i, a_i, b_i,
        output diff_o, diff_vld_o, busy_o, done_o, borrow_o, result_o, zero_o
    );
`else
    modport master (
        output start_i, a_i, b_i,
        input  diff_o, diff_vld_o, busy_o, done_o, borrow_o, result_o
    );
    modport slave (
        input  start_i, a_i, b_i,
        output diff_o, diff_vld_o, busy_o, done_o, borrow_o, result_o
    );
`endif
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module sersub_fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, operands LSB first; streams the difference and assembles it in parallel.
// Optional zero flag built when SERSUB_ZERO_FLAG_EN is defined.
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sersub_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_diff;
    logic             r_diff_vld;
    logic             r_borrow_out;
    logic [WIDTH-1:0] r_result;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_result_next;

    sersub_fs_cell u_cell (
        .a    (bus.a_i),
        .b    (bus.b_i),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // New bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign w_result_next = {w_d, r_result[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= 1'b0;
            r_diff_vld   <= 1'b0;
            r_borrow_out <= 1'b0;
            r_result     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_diff_vld <= 1'b0;
                    if (bus.start_i) begin
                        r_state  <= ST_RUN;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_result <= '0;
                    end
                end
                ST_RUN: begin
                    r_diff     <= w_d;
                    r_diff_vld <= 1'b1;
                    r_borrow   <= w_bout;
                    r_result   <= w_result_next;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state      <= ST_DONE;
                        r_borrow_out <= w_bout;
                    end
                end
                default: begin
                    r_diff_vld <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERSUB_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start_i) begin
            r_zero <= 1'b0;
        end else if (r_state == ST_RUN && r_cnt == LAST_CNT) begin
            r_zero <= (w_result_next == '0);
        end
    end

    assign bus.zero_o = r_zero;
`endif

    assign bus.diff_o     = r_diff;
    assign bus.diff_vld_o = r_diff_vld;
    assign bus.busy_o     = (r_state == ST_RUN);
    assign bus.done_o     = (r_state == ST_DONE);
    assign bus.borrow_o   = r_borrow_out;
    assign bus.result_o   = r_result;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=5); zero_o checked when
// SERSUB_ZERO_FLAG_EN is defined.
module tb_serial_subtractor;
    localparam int W = 5;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts from an IDLE negedge and returns on the idle negedge after DONE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input logic exp_bw, input logic exp_z);
        chk({tag, ":idle_busy"}, 32'(bus.busy_o), 32'd0);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int k = 0; k < W; k++) begin
            bus.a_i = a[k];
            bus.b_i = b[k];
            chk({tag, ":busy"}, 32'(bus.busy_o), 32'd1);
            @(negedge clk);
            chk({tag, ":diff_vld"}, 32'(bus.diff_vld_o), 32'd1);
            chk({tag, ":diff_bit"}, 32'(bus.diff_o), 32'(exp_r[k]));
            chk({tag, ":done_timing"}, 32'(bus.done_o), (k == W - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, ":result"}, 32'(bus.result_o), 32'(exp_r));
        chk({tag, ":borrow"}, 32'(bus.borrow_o), 32'(exp_bw));
`ifdef SERSUB_ZERO_FLAG_EN
        chk({tag, ":zero"}, 32'(bus.zero_o), 32'(exp_z));
`else
        if (exp_z === 1'bx) $display("[TB] unexpected zero arg");
`endif
        bus.a_i = 1'b0;
        bus.b_i = 1'b0;
        @(negedge clk);
        chk({tag, ":done_clear"}, 32'(bus.done_o), 32'd0);
        chk({tag, ":vld_clear"}, 32'(bus.diff_vld_o), 32'd0);
        chk({tag, ":result_hold"}, 32'(bus.result_o), 32'(exp_r));
        chk({tag, ":borrow_hold"}, 32'(bus.borrow_o), 32'(exp_bw));
        $display("[TB] op %s A=%0d B=%0d -> result=%0d borrow=%0b", tag, a, b,
                 bus.result_o, bus.borrow_o);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i     = 1'b0;
        bus.b_i     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_vld", 32'(bus.diff_vld_o), 32'd0);
        chk("rst_diff", 32'(bus.diff_o), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_o), 32'd0);
        chk("rst_result", 32'(bus.result_o), 32'd0);
`ifdef SERSUB_ZERO_FLAG_EN
        chk("rst_zero", 32'(bus.zero_o), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset released");

        run_op("9-3",   5'd9,  5'd3,  5'd6,  1'b0, 1'b0);
        run_op("3-9",   5'd3,  5'd9,  5'd26, 1'b1, 1'b0);
        run_op("21-21", 5'd21, 5'd21, 5'd0,  1'b0, 1'b1);
        run_op("0-31",  5'd0,  5'd31, 5'd1,  1'b1, 1'b0);

        // Reset asserted in cycle 3 of a run aborts it without a done pulse.
        bus.start_i = 1'b1;
        bus.a_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_done", 32'(bus.done_o), 32'd0);
        chk("abort_vld", 32'(bus.diff_vld_o), 32'd0);
        chk("abort_diff", 32'(bus.diff_o), 32'd0);
        chk("abort_borrow", 32'(bus.borrow_o), 32'd0);
        chk("abort_result", 32'(bus.result_o), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        bus.a_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done_o), 32'd0);
            chk("abort_idle", 32'(bus.busy_o), 32'd0);
        end
        $display("[TB] abort by reset checked");
        run_op("16-1", 5'd16, 5'd1, 5'd15, 1'b0, 1'b0);

        // start_i held high: one accepted start every 7 cycles.
        bus.start_i = 1'b1;
        bus.a_i     = 1'b1;
        bus.b_i     = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W + 2; c++) begin
                chk("cont_busy", 32'(bus.busy_o), (c >= 1 && c <= W) ? 32'd1 : 32'd0);
                chk("cont_done", 32'(bus.done_o), (c == W + 1) ? 32'd1 : 32'd0);
                if (c == W + 1) begin
                    chk("cont_result", 32'(bus.result_o), 32'd31);
                    chk("cont_borrow", 32'(bus.borrow_o), 32'd0);
                end
                @(negedge clk);
            end
            $display("[TB] continuous run %0d result=%0d", r, bus.result_o);
        end
        bus.start_i = 1'b0;
        bus.a_i     = 1'b0;
        @(negedge clk);
        chk("cont_stop", 32'(bus.busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
